// File: rtl/kernel_mac.sv
// Sequential SIZE x SIZE multiply-accumulate over a latched kernel and pixel window,
// producing one rounded, saturated result per start with a valid/ready handshake.
module kernel_mac #(
  parameter  int SIZE   = 3,
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int FRAC   = 8,
  localparam int IDX_W  = $clog2(SIZE),
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(SIZE * SIZE)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [SIZE-1:0][SIZE-1:0][COEF_W-1:0] kernel,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] window,
  output logic                                  busy,
  output logic [IDX_W-1:0]                      cur_x,
  output logic [IDX_W-1:0]                      cur_y,
  output logic [COEF_W-1:0]                     kernel_v,
  output logic [DATA_W-1:0]                     pixel_v,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_W-1:0]                     result,
  output logic [ACC_W-1:0]                      acc_raw
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(SIZE - 1);
  localparam logic [ACC_W:0]   HALF    = (ACC_W + 1)'(1) << (FRAC - 1);
  localparam logic [ACC_W:0]   RES_MAX = {{(ACC_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  state_t                                state;
  logic [SIZE-1:0][SIZE-1:0][COEF_W-1:0] snap_k;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] snap_w;
  logic [DATA_W+COEF_W-1:0]              prod;
  logic [ACC_W-1:0]                      acc_sum;
  logic [ACC_W:0]                        rounded;
  logic [DATA_W-1:0]                     sat_res;

  // The element under the index comes from the snapshot, never the live inputs.
  assign kernel_v = snap_k[cur_x][cur_y];
  assign pixel_v  = snap_w[cur_x][cur_y];
  assign prod     = {{DATA_W{1'b0}}, kernel_v} * {{COEF_W{1'b0}}, pixel_v};
  assign acc_sum  = acc_raw + {{(ACC_W - DATA_W - COEF_W){1'b0}}, prod};

  // Round half-up from the final sum, then clamp to the output range.
  assign rounded  = ({1'b0, acc_sum} + HALF) >> FRAC;
  assign sat_res  = (rounded > RES_MAX) ? {DATA_W{1'b1}} : rounded[DATA_W-1:0];

  // NOTE: every register here uses <= so all updates see pre-edge values; mixing in
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      acc_raw   <= '0;
      result    <= '0;
      // NOTE: the snapshot is a small register array, not a RAM, so it can and must be
      // cleared here; a real memory macro would not take a reset.
      snap_k    <= '0;
      snap_w    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_k  <= kernel;
            snap_w  <= window;
            acc_raw <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            acc_raw <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            acc_raw <= acc_sum;
            if (cur_x == LAST) begin
              cur_x <= '0;
              if (cur_y == LAST) begin
                cur_y     <= '0;
                result    <= sat_res;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                cur_y <= cur_y + IDX_W'(1);
              end
            end else begin
              cur_x <= cur_x + IDX_W'(1);
            end
          end
        end

        DONE: begin
          if (abort) begin
            acc_raw   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_mac.sv
// Self-checking bench for kernel_mac: directed table, randomized runs against a plain
// arithmetic model, control corner cases, and a SIZE=5 / FRAC=4 instance.
module tb_kernel_mac;

  localparam int S   = 3;
  localparam int FR  = 8;
  localparam int S5  = 5;
  localparam int FR5 = 4;

  typedef logic [S-1:0][S-1:0][7:0]   mat3_t;
  typedef logic [S5-1:0][S5-1:0][7:0] mat5_t;
  typedef struct {
    string      name;
    mat3_t      k;
    mat3_t      w;
    logic [63:0] acc;
    logic [63:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  mat3_t       kernel, window;
  logic        busy, out_valid;
  logic [1:0]  cur_x, cur_y;
  logic [7:0]  kernel_v, pixel_v, result;
  logic [19:0] acc_raw;

  logic        b_start, b_abort, b_out_ready;
  mat5_t       b_kernel, b_window;
  logic        b_busy, b_out_valid;
  logic [2:0]  b_cur_x, b_cur_y;
  logic [7:0]  b_kernel_v, b_pixel_v, b_result;
  logic [20:0] b_acc_raw;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kernel_mac dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .kernel(kernel), .window(window), .busy(busy),
    .cur_x(cur_x), .cur_y(cur_y), .kernel_v(kernel_v), .pixel_v(pixel_v),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .acc_raw(acc_raw)
  );

  kernel_mac #(.SIZE(S5), .FRAC(FR5)) dut5 (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .kernel(b_kernel), .window(b_window), .busy(b_busy),
    .cur_x(b_cur_x), .cur_y(b_cur_y), .kernel_v(b_kernel_v), .pixel_v(b_pixel_v),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result), .acc_raw(b_acc_raw)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic mat3_t uniform3(input int v);
    mat3_t m;
    for (int x = 0; x < S; x++)
      for (int y = 0; y < S; y++)
        m[x][y] = 8'(v);
    return m;
  endfunction

  // Reference: sum of products, round half-up at FRAC bits, clamp to 8 bits.
  task automatic ref_conv(input mat3_t k, input mat3_t w,
                          output logic [63:0] acc, output logic [63:0] res);
    longint s = 0;
    longint r;
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++)
        s += longint'(k[x][y]) * longint'(w[x][y]);
    r = (s + (longint'(1) << (FR - 1))) >> FR;
    if (r > 255) r = 255;
    acc = 64'(s);
    res = 64'(r);
  endtask

  // One full operation on the SIZE=3 instance; checks index walk, element values,
  // latency and the return to IDLE after the handshake.
  task automatic conv3(input string name, input mat3_t k, input mat3_t w, input bit abort_on_start,
                       output logic [63:0] acc, output logic [63:0] res);
    int lat;
    kernel    = k;
    window    = w;
    start     = 1'b1;
    abort     = abort_on_start;
    out_ready = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    abort  = 1'b0;
    kernel = mat3_t'({$urandom, $urandom, $urandom});
    window = mat3_t'({$urandom, $urandom, $urandom});
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (lat < S * S) begin
        check({name, "_cur_x"}, 64'(cur_x), 64'(lat % S));
        check({name, "_cur_y"}, 64'(cur_y), 64'(lat / S));
        check({name, "_kernel_v"}, 64'(kernel_v), 64'(k[lat % S][lat / S]));
        check({name, "_pixel_v"}, 64'(pixel_v), 64'(w[lat % S][lat / S]));
      end
      @(negedge clk);
      lat++;
    end
    // Valid is first sampled by a consumer at edge N+SIZE*SIZE+1.
    check({name, "_latency"}, 64'(lat), 64'(S * S));
    acc = 64'(acc_raw);
    res = 64'(result);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
    check({name, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  vec_t        vecs[5];
  int          gk[3][3] = '{'{25, 29, 25}, '{29, 33, 29}, '{25, 29, 25}};
  int          gw[3][3] = '{'{25, 100, 25}, '{50, 150, 50}, '{25, 100, 25}};
  mat3_t       g_k, g_w, rk, rw;
  logic [63:0] got_acc, got_res, exp_acc, exp_res;
  int          lat, cnt;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    kernel = '0; window = '0;
    b_start = 1'b0; b_abort = 1'b0; b_out_ready = 1'b0;
    b_kernel = '0; b_window = '0;

    for (int x = 0; x < S; x++)
      for (int y = 0; y < S; y++) begin
        g_k[x][y] = 8'(gk[y][x]);
        g_w[x][y] = 8'(gw[y][x]);
      end
    vecs[0] = '{"gauss",   g_k,           g_w,            64'd16150,  64'd63};
    vecs[1] = '{"sat",     uniform3(255), uniform3(255),  64'd585225, 64'd255};
    vecs[2] = '{"uniform", uniform3(28),  uniform3(100),  64'd25200,  64'd98};
    vecs[3] = '{"zero",    uniform3(0),   uniform3(77),   64'd0,      64'd0};
    vecs[4] = '{"unit",    uniform3(1),   uniform3(255),  64'd2295,   64'd9};

    @(negedge clk);
    @(negedge clk);
    check("rst_busy",     64'(busy),      64'd0);
    check("rst_valid",    64'(out_valid), 64'd0);
    check("rst_cur_x",    64'(cur_x),     64'd0);
    check("rst_cur_y",    64'(cur_y),     64'd0);
    check("rst_acc",      64'(acc_raw),   64'd0);
    check("rst_result",   64'(result),    64'd0);
    check("rst_kernel_v", 64'(kernel_v),  64'd0);
    check("rst_pixel_v",  64'(pixel_v),   64'd0);
    check("rst_b_valid",  64'(b_out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      conv3(vecs[i].name, vecs[i].k, vecs[i].w, 1'b0, got_acc, got_res);
      check({vecs[i].name, "_acc"}, got_acc, vecs[i].acc);
      check({vecs[i].name, "_result"}, got_res, vecs[i].res);
    end

    for (int t = 0; t < 20; t++) begin
      for (int x = 0; x < S; x++)
        for (int y = 0; y < S; y++) begin
          rk[x][y] = (t % 4 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
          rw[x][y] = (t % 4 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
        end
      ref_conv(rk, rw, exp_acc, exp_res);
      conv3("rand", rk, rw, 1'b0, got_acc, got_res);
      check("rand_acc", got_acc, exp_acc);
      check("rand_result", got_res, exp_res);
    end

    // Backpressure with start pulses in RUN and DONE, then start during the handshake.
    kernel = uniform3(28); window = uniform3(100); start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      start = (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("bp_latency", 64'(lat), 64'(S * S));
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      check("bp_hold_valid",  64'(out_valid), 64'd1);
      check("bp_hold_acc",    64'(acc_raw),   64'd25200);
      check("bp_hold_result", 64'(result),    64'd98);
      @(negedge clk);
    end
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    check("bp_idle_busy",   64'(busy),      64'd0);
    check("bp_idle_valid",  64'(out_valid), 64'd0);
    check("bp_idle_acc",    64'(acc_raw),   64'd25200);
    check("bp_idle_result", 64'(result),    64'd98);
    check("bp_idle_cur",    64'({cur_x, cur_y}), 64'd0);
    check("bp_idle_kv",     64'(kernel_v),  64'd28);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt++;
    end
    check("bp_no_second_run", 64'(cnt), 64'd0);

    // Abort in the 4th RUN cycle.
    kernel = g_k; window = g_w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_run_busy",  64'(busy),      64'd0);
    check("abort_run_valid", 64'(out_valid), 64'd0);
    check("abort_run_acc",   64'(acc_raw),   64'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) cnt++;
    end
    check("abort_run_no_valid", 64'(cnt), 64'd0);
    conv3("after_abort", g_k, g_w, 1'b0, got_acc, got_res);
    check("after_abort_acc", got_acc, 64'd16150);
    check("after_abort_result", got_res, 64'd63);

    // Abort while holding a result in DONE.
    kernel = uniform3(28); window = uniform3(100); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (S * S) @(negedge clk);
    check("abort_done_pre_valid", 64'(out_valid), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_valid", 64'(out_valid), 64'd0);
    check("abort_done_busy",  64'(busy),      64'd0);
    check("abort_done_acc",   64'(acc_raw),   64'd0);

    // Abort together with start in IDLE: start wins.
    conv3("abort_start", uniform3(28), uniform3(100), 1'b1, got_acc, got_res);
    check("abort_start_acc", got_acc, 64'd25200);
    check("abort_start_result", got_res, 64'd98);

    // Reset mid-RUN, then mid-DONE.
    for (int phase = 0; phase < 2; phase++) begin
      kernel = g_k; window = g_w; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat ((phase == 0) ? 4 : S * S + 1) @(negedge clk);
      check("rst_mid_pre_busy", 64'(busy), 64'd1);
      rst = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0;
      check("rst_mid_busy",   64'(busy),      64'd0);
      check("rst_mid_valid",  64'(out_valid), 64'd0);
      check("rst_mid_cur",    64'({cur_x, cur_y}), 64'd0);
      check("rst_mid_acc",    64'(acc_raw),   64'd0);
      check("rst_mid_result", 64'(result),    64'd0);
      check("rst_mid_kv",     64'(kernel_v),  64'd0);
      check("rst_mid_pv",     64'(pixel_v),   64'd0);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b0 || busy !== 1'b0) cnt++;
      end
      check("rst_mid_no_valid", 64'(cnt), 64'd0);
    end

    // SIZE=5, FRAC=4 instance.
    for (int x = 0; x < S5; x++)
      for (int y = 0; y < S5; y++) begin
        b_kernel[x][y] = 8'd16;
        b_window[x][y] = 8'd1;
      end
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; lat = 0;
    while (b_out_valid !== 1'b1 && lat < 200) begin
      if (lat < S5 * S5) begin
        check("s5_cur_x", 64'(b_cur_x), 64'(lat % S5));
        check("s5_cur_y", 64'(b_cur_y), 64'(lat / S5));
      end
      @(negedge clk);
      lat++;
    end
    check("s5_latency", 64'(lat),       64'(S5 * S5));
    check("s5_acc",     64'(b_acc_raw), 64'd400);
    check("s5_result",  64'(b_result),  64'd25);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("s5_idle_busy", 64'(b_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
